// File: rtl/tmds_pkg.sv
// Shared TMDS symbol constants, pipeline mode type and bit-count helper.
package tmds_pkg;

    localparam logic [9:0] CTL_00  = 10'b1101010100;
    localparam logic [9:0] CTL_01  = 10'b0010101011;
    localparam logic [9:0] CTL_10  = 10'b0101010100;
    localparam logic [9:0] CTL_11  = 10'b1010101011;
    localparam logic [9:0] GUARD_A = 10'b1011001100;
    localparam logic [9:0] GUARD_B = 10'b0100110011;

    typedef enum logic [1:0] {
        VIDEO,
        CTRL,
        GUARD
    } mode_e;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctl_code(input logic [1:0] c);
        logic [9:0] s;
        unique case (c)
            2'b00:   s = CTL_00;
            2'b01:   s = CTL_01;
            2'b10:   s = CTL_10;
            default: s = CTL_11;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tmds_channel.sv
// One TMDS lane: transition-minimise stage, then DC-balance stage with
// running disparity; control and guard symbols bypass the balancer.
import tmds_pkg::*;

module tmds_channel #(
    parameter int C_index = 0
) (
    input  logic       clk_pixel,
    input  logic       resetn,
    input  logic [7:0] d_in,
    input  mode_e      mode_in,
    input  logic [1:0] ctl_in,
    output logic [9:0] tmds_out
);

    logic [8:0]        qm_d, qm_q;
    mode_e             mode_d, mode_q;
    logic [1:0]        ctl_d, ctl_q;
    logic [9:0]        tmds_d, tmds_q;
    logic signed [4:0] cnt_d, cnt_q;

    logic [3:0]        n1d;
    logic              use_xnor;
    logic [3:0]        n1;
    logic              qm8;
    logic signed [5:0] diff;
    logic signed [5:0] cnt6;
    logic signed [5:0] sum;

    always_comb begin
        n1d      = popcount8(d_in);
        use_xnor = (n1d > 4'd4) || (n1d == 4'd4 && !d_in[0]);
        qm_d     = '0;
        qm_d[0]  = d_in[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ d_in[i])
                               : (qm_d[i-1] ^ d_in[i]);
        end
        qm_d[8]  = ~use_xnor;
        mode_d   = mode_in;
        ctl_d    = ctl_in;
    end

    // diff = n1 - n0 = 2*n1 - 8, kept in 6 bits so the sum cannot wrap
    always_comb begin
        n1     = popcount8(qm_q[7:0]);
        qm8    = qm_q[8];
        diff   = $signed({1'b0, n1, 1'b0}) - 6'sd8;
        cnt6   = {cnt_q[4], cnt_q};
        sum    = '0;
        tmds_d = CTL_00;
        cnt_d  = '0;
        unique case (mode_q)
            VIDEO: begin
                if (cnt_q == 5'sd0 || diff == 6'sd0) begin
                    tmds_d = {~qm8, qm8, qm8 ? qm_q[7:0] : ~qm_q[7:0]};
                    sum    = qm8 ? cnt6 + diff : cnt6 - diff;
                end else if ((!cnt_q[4] && diff > 6'sd0) ||
                             (cnt_q[4] && diff < 6'sd0)) begin
                    tmds_d = {1'b1, qm8, ~qm_q[7:0]};
                    sum    = cnt6 + (qm8 ? 6'sd2 : 6'sd0) - diff;
                end else begin
                    tmds_d = {1'b0, qm8, qm_q[7:0]};
                    sum    = cnt6 + diff - (qm8 ? 6'sd0 : 6'sd2);
                end
                cnt_d = sum[4:0];
            end
            GUARD:   tmds_d = (C_index == 1) ? GUARD_B : GUARD_A;
            default: tmds_d = ctl_code(ctl_q);
        endcase
    end

    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            qm_q   <= '0;
            mode_q <= CTRL;
            ctl_q  <= '0;
            tmds_q <= CTL_00;
            cnt_q  <= '0;
        end else begin
            qm_q   <= qm_d;
            mode_q <= mode_d;
            ctl_q  <= ctl_d;
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tmds_out = tmds_q;

endmodule

// File: rtl/tmds_encoder_multi.sv
// N-lane TMDS encoder: depth expansion, mode decode and control-pair
// routing feeding one tmds_channel per lane.
import tmds_pkg::*;

module tmds_encoder_multi #(
    parameter int C_channels = 3,
    parameter int C_depth    = 8,
    parameter int C_guard    = 1
) (
    input  logic                            clk_pixel,
    input  logic                            resetn,
    input  logic [C_channels*C_depth-1:0]   pixel_in,
    input  logic                            blank,
    input  logic                            hsync,
    input  logic                            vsync,
    input  logic [2*C_channels-1:0]         ctl,
    input  logic                            guard,
    output logic [10*C_channels-1:0]        tmds_out,
    output logic                            valid_out
);

    mode_e mode;
    logic  guard_en;
    logic  v1_d, v1_q;
    logic  v2_d, v2_q;
    logic  unused_ctl;

    // lane 0 takes its control pair from the syncs instead
    assign unused_ctl = ^ctl[1:0];

    always_comb begin
        guard_en = blank && guard && (C_guard != 0);
        mode     = CTRL;
        unique case (1'b1)
            !blank:   mode = VIDEO;
            guard_en: mode = GUARD;
            default:  mode = CTRL;
        endcase
    end

    always_comb begin
        v1_d = 1'b1;
        v2_d = v1_q;
    end

    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    assign valid_out = v2_q;

    for (genvar k = 0; k < C_channels; k++) begin : g_ch
        logic [C_depth-1:0] p;
        logic [7:0]         d;
        logic [1:0]         pair;

        // MSB-first replication fills all 8 bits from a narrower sample
        always_comb begin
            p = pixel_in[k*C_depth +: C_depth];
            d = '0;
            for (int i = 0; i < 8; i++) begin
                d[7-i] = p[C_depth-1-(i % C_depth)];
            end
        end

        if (k == 0) begin : g_sync
            assign pair = {vsync, hsync};
        end else begin : g_ctl
            assign pair = ctl[2*k +: 2];
        end

        tmds_channel #(
            .C_index (k)
        ) u_ch (
            .clk_pixel (clk_pixel),
            .resetn    (resetn),
            .d_in      (d),
            .mode_in   (mode),
            .ctl_in    (pair),
            .tmds_out  (tmds_out[10*k +: 10])
        );
    end

endmodule
